// File: rtl/microwave_pkg.sv
// Shared types and 7-segment letter constants for the microwave controller.
// Segment vectors are gfedcba, active-low.
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COOK,
    PAUSE,
    DONE
  } state_e;

  localparam logic [6:0] SegI = 7'b1111001;
  localparam logic [6:0] SegD = 7'b0100001;
  localparam logic [6:0] SegL = 7'b1000111;
  localparam logic [6:0] SegE = 7'b0000110;
  localparam logic [6:0] SegP = 7'b0001100;
  localparam logic [6:0] SegR = 7'b0101111;
  localparam logic [6:0] SegO = 7'b1000000;
  localparam logic [6:0] SegC = 7'b1000110;
  localparam logic [6:0] SegN = 7'b0101011;
  localparam logic [6:0] SegA = 7'b0001000;
  localparam logic [6:0] SegU = 7'b1000001;
  localparam logic [6:0] SegS = 7'b0010010;

endpackage

// File: rtl/mw_state_seg.sv
// Maps the controller state onto four letter digits, leftmost digit on seg1_o.
module mw_state_seg
  import microwave_pkg::*;
(
  input  state_e     state_i,
  output logic [6:0] seg1_o,
  output logic [6:0] seg2_o,
  output logic [6:0] seg3_o,
  output logic [6:0] seg4_o
);

  always_comb begin
    seg1_o = SegI;
    seg2_o = SegD;
    seg3_o = SegL;
    seg4_o = SegE;
    unique case (state_i)
      IDLE: begin
        seg1_o = SegI;
        seg2_o = SegD;
        seg3_o = SegL;
        seg4_o = SegE;
      end
      COOK: begin
        seg1_o = SegP;
        seg2_o = SegR;
        seg3_o = SegO;
        seg4_o = SegC;
      end
      PAUSE: begin
        seg1_o = SegP;
        seg2_o = SegA;
        seg3_o = SegU;
        seg4_o = SegS;
      end
      DONE: begin
        seg1_o = SegD;
        seg2_o = SegO;
        seg3_o = SegN;
        seg4_o = SegE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/microwave_ctrl_p.sv
// Microwave oven controller: second countdown with pause/resume, duty-cycled
// magnetron enable and a timed completion beeper.
module microwave_ctrl_p
  import microwave_pkg::*;
#(
  parameter int unsigned TIME_W        = 7,
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned PWR_LEVELS    = 2,
  parameter int unsigned BEEP_SEC      = 3,
  localparam int unsigned PWR_W        = (PWR_LEVELS > 1) ? $clog2(PWR_LEVELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWR_W-1:0]  power,
  input  logic [TIME_W-1:0] timer,
  input  logic              door_status,
  input  logic              start_button,
  input  logic              cancel_button,
  output logic [6:0]        state_display1,
  output logic [6:0]        state_display2,
  output logic [6:0]        state_display3,
  output logic [6:0]        state_display4,
  output logic [TIME_W-1:0] time_display,
  output logic              magnetron_on,
  output logic              beeper
);

  localparam int unsigned TickW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned BeepCyc = BEEP_SEC * TICKS_PER_SEC;
  localparam int unsigned BeepW   = (BeepCyc > 1) ? $clog2(BeepCyc) : 1;

  localparam logic [TickW-1:0] TickMax = TickW'(TICKS_PER_SEC - 1);
  localparam logic [PWR_W-1:0] DutyMax = PWR_W'(PWR_LEVELS - 1);
  localparam logic [BeepW-1:0] BeepMax = BeepW'(BeepCyc - 1);

  state_e              state_q, state_d;
  logic                start_q;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [PWR_W-1:0]    duty_q, duty_d;
  logic [PWR_W-1:0]    pwr_q, pwr_d;
  logic [BeepW-1:0]    beep_cnt_q, beep_cnt_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                mag_q, mag_d;
  logic                beep_q, beep_d;
  logic                start_rise;
  logic                tick_wrap;

  assign start_rise = start_button & ~start_q;
  assign tick_wrap  = (tick_q == TickMax);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    duty_d     = duty_q;
    pwr_d      = pwr_q;
    beep_cnt_d = beep_cnt_q;
    time_d     = time_q;
    beep_d     = beep_q;
    unique case (state_q)
      IDLE: begin
        if (!cancel_button && door_status && start_rise && (timer != '0)) begin
          state_d = COOK;
          time_d  = timer;
          pwr_d   = power;
          tick_d  = '0;
          duty_d  = '0;
        end
      end
      COOK: begin
        if (cancel_button) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (!door_status) begin
          state_d = PAUSE;
        end else if (tick_wrap) begin
          tick_d = '0;
          duty_d = (duty_q == DutyMax) ? '0 : duty_q + 1'b1;
          if (time_q == TIME_W'(1)) begin
            state_d    = DONE;
            time_d     = '0;
            beep_d     = (BeepCyc != 0);
            beep_cnt_d = '0;
          end else if (time_q != '0) begin
            time_d = time_q - 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      PAUSE: begin
        if (cancel_button) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (door_status && start_rise) begin
          state_d = COOK;
          pwr_d   = power;
          duty_d  = '0;
        end
      end
      DONE: begin
        if (cancel_button || !door_status) begin
          state_d = IDLE;
          beep_d  = 1'b0;
        end else if (beep_q) begin
          if (beep_cnt_q == BeepMax) begin
            beep_d = 1'b0;
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered enable follows the next state so it switches on the same edge.
    mag_d = (state_d == COOK) && (duty_d <= pwr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      tick_q     <= '0;
      duty_q     <= '0;
      pwr_q      <= '0;
      beep_cnt_q <= '0;
      time_q     <= '0;
      mag_q      <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_button;
      tick_q     <= tick_d;
      duty_q     <= duty_d;
      pwr_q      <= pwr_d;
      beep_cnt_q <= beep_cnt_d;
      time_q     <= time_d;
      mag_q      <= mag_d;
      beep_q     <= beep_d;
    end
  end

  assign time_display = time_q;
  assign magnetron_on = mag_q;
  assign beeper       = beep_q;

  mw_state_seg u_seg (
    .state_i (state_q),
    .seg1_o  (state_display1),
    .seg2_o  (state_display2),
    .seg3_o  (state_display3),
    .seg4_o  (state_display4)
  );

endmodule
